// File: rtl/jet_pkg.sv
// jet_pkg: movement/fire keycodes, direction type and helpers shared by the keycode arbiter
// and the jet movement controller.
//   KEY_W/A/S/D/FIRE  HID usage codes on the 8-bit movement keycode bus
//   dir_t             registered movement direction
//   fire_state_t      fire rate limiter state
//   dir2code()        direction -> bus keycode
//   dir2mask()        direction -> {W,A,S,D} one-hot
//   pick_dir()        highest-priority (W>A>S>D) key of a {W,A,S,D} mask
package jet_pkg;
   localparam logic [7:0] KEY_NONE = 8'h00;
   localparam logic [7:0] KEY_W    = 8'h1A;
   localparam logic [7:0] KEY_A    = 8'h04;
   localparam logic [7:0] KEY_S    = 8'h16;
   localparam logic [7:0] KEY_D    = 8'h07;
   localparam logic [7:0] KEY_FIRE = 8'h2C;
   typedef enum logic [2:0] {DIR_NONE, DIR_W, DIR_A, DIR_S, DIR_D} dir_t;
   typedef enum logic {FIRE_READY, FIRE_COOL} fire_state_t;
   function automatic logic [7:0] dir2code(input dir_t d);
      return d == DIR_W ? KEY_W :
             d == DIR_A ? KEY_A :
             d == DIR_S ? KEY_S :
             d == DIR_D ? KEY_D : KEY_NONE;
   endfunction
   function automatic logic [3:0] dir2mask(input dir_t d);
      return d == DIR_W ? 4'b1000 :
             d == DIR_A ? 4'b0100 :
             d == DIR_S ? 4'b0010 :
             d == DIR_D ? 4'b0001 : 4'b0000;
   endfunction
   function automatic dir_t pick_dir(input logic [3:0] m);
      return m[3] ? DIR_W :
             m[2] ? DIR_A :
             m[1] ? DIR_S :
             m[0] ? DIR_D : DIR_NONE;
   endfunction
endpackage

// File: rtl/fire_timer.sv
// fire_timer: rate-limited fire request generator for the missile spawner.
//   frame_clk   in   frame clock
//   Reset       in   asynchronous, active-high
//   held        in   fire key present in this frame's report
//   fire_pulse  out  one-frame fire request, at most one per FIRE_COOLDOWN frames
//   fire_ready  out  1 while no cooldown is running
module fire_timer
   import jet_pkg::*;
#(
   parameter int FIRE_COOLDOWN = 15
) (
   input  logic frame_clk,
   input  logic Reset,
   input  logic held,
   output logic fire_pulse,
   output logic fire_ready
);
   localparam logic [7:0] RELOAD = 8'(FIRE_COOLDOWN - 1);
   localparam bit EVERY_FRAME = (FIRE_COOLDOWN == 1);

   if (FIRE_COOLDOWN < 1 || FIRE_COOLDOWN > 255) begin : g_bad_cooldown
      $error("fire_timer: FIRE_COOLDOWN must be in 1..255");
   end

   fire_state_t state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic        pulse_n;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state      <= FIRE_READY;
         cnt        <= 8'd0;
         fire_pulse <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         fire_pulse <= pulse_n;
      end
   end

   // cnt==1 is the last cooldown frame: a released key frees the timer there, while a held
   // key runs one more edge (cnt==0) so repeats land exactly FIRE_COOLDOWN frames apart
   // without fire_ready flickering high between them.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pulse_n = 1'b0;
      if (state == FIRE_READY) begin
         pulse_n = held;
         state_n = (held && !EVERY_FRAME) ? FIRE_COOL : FIRE_READY;
         cnt_n   = (held && !EVERY_FRAME) ? RELOAD : 8'd0;
      end else if (cnt == 8'd0) begin
         pulse_n = held;
         state_n = held ? FIRE_COOL : FIRE_READY;
         cnt_n   = held ? RELOAD : 8'd0;
      end else if (cnt == 8'd1 && !held) begin
         state_n = FIRE_READY;
         cnt_n   = 8'd0;
      end else begin
         cnt_n = cnt - 8'd1;
      end
   end

   assign fire_ready = (state == FIRE_READY);
endmodule

// File: rtl/keycode_arbiter.sv
// keycode_arbiter: reduces the 6-slot HID keyboard report to one movement keycode
// (last-pressed-wins among W/A/S/D) and a rate-limited fire pulse.
//   frame_clk     in   one edge per video frame
//   Reset         in   asynchronous, active-high
//   report_keys   in   slot i = report_keys[8i+7:8i], 8'h00 = empty
//   move_keycode  out  registered direction keycode (1A/04/16/07, 00 = none)
//   held_mask     out  registered {W,A,S,D} held bits of the last sample
//   fire_pulse    out  one-frame fire request
//   fire_ready    out  1 when the fire cooldown has expired
module keycode_arbiter
   import jet_pkg::*;
#(
   parameter int          NUM_SLOTS     = 6,
   parameter logic [7:0]  FIRE_KEY      = KEY_FIRE,
   parameter int          FIRE_COOLDOWN = 15
) (
   input  logic                     frame_clk,
   input  logic                     Reset,
   input  logic [8*NUM_SLOTS-1:0]   report_keys,
   output logic [7:0]               move_keycode,
   output logic [3:0]               held_mask,
   output logic                     fire_pulse,
   output logic                     fire_ready
);
   logic [3:0] held_n, new_keys;
   logic       fire_held, dir_held;
   dir_t       dir, dir_n;

   // Duplicate codes just re-set the same bit; unknown codes match nothing.
   always_comb begin
      held_n    = 4'b0000;
      fire_held = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         held_n[3] = held_n[3] | (report_keys[8*i +: 8] == KEY_W);
         held_n[2] = held_n[2] | (report_keys[8*i +: 8] == KEY_A);
         held_n[1] = held_n[1] | (report_keys[8*i +: 8] == KEY_S);
         held_n[0] = held_n[0] | (report_keys[8*i +: 8] == KEY_D);
         fire_held = fire_held | (report_keys[8*i +: 8] == FIRE_KEY);
      end
   end

   assign new_keys = held_n & ~held_mask;
   assign dir_held = |(dir2mask(dir) & held_n);
   // A fresh press wins; otherwise keep the current key while held, then fall back by priority.
   assign dir_n = |new_keys ? pick_dir(new_keys) :
                  dir_held  ? dir : pick_dir(held_n);

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         dir          <= DIR_NONE;
         held_mask    <= 4'b0000;
         move_keycode <= KEY_NONE;
      end else begin
         dir          <= dir_n;
         held_mask    <= held_n;
         move_keycode <= dir2code(dir_n);
      end
   end

   fire_timer #(.FIRE_COOLDOWN(FIRE_COOLDOWN)) u_fire_timer (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .held       (fire_held),
      .fire_pulse (fire_pulse),
      .fire_ready (fire_ready)
   );
endmodule
